// File: rtl/approx_mult_ctrl_if.sv
// approx_mult_ctrl_if: handshake and strobe bundle between the sequencer and its datapath
interface approx_mult_ctrl_if;
  logic       start;
  logic       msb_a;
  logic       msb_b;
  logic [3:0] in_addr;
  logic       ld_a;
  logic       ld_b;
  logic       shl_a;
  logic       shl_b;
  logic       reg_ld;
  logic [4:0] shift_total;
  logic       out_wen;
  logic [2:0] out_addr;
  logic       busy;
  logic       done;
  modport master (
    input  start, msb_a, msb_b,
    output in_addr, ld_a, ld_b, shl_a, shl_b, reg_ld, shift_total, out_wen, out_addr, busy, done
  );
  modport slave (
    output start, msb_a, msb_b,
    input  in_addr, ld_a, ld_b, shl_a, shl_b, reg_ld, shift_total, out_wen, out_addr, busy, done
  );
endinterface

// File: rtl/approx_mult_ctrl.sv
// approx_mult_ctrl: sequencer that fetches, normalises, multiplies and stores N_PAIRS operand pairs
module approx_mult_ctrl #(
  parameter int N_PAIRS   = 8,
  parameter int MAX_SHIFT = 8
) (
  input logic clk,
  input logic rst,
  approx_mult_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, NORM, CAPTURE, WRITE, DONE} state_t;
  localparam logic [3:0] MAX  = 4'(MAX_SHIFT);
  localparam logic [2:0] LAST = 3'(N_PAIRS - 1);
  state_t     state, state_n;
  logic [2:0] k;
  logic [3:0] sa, sb;
  logic       shl_a, shl_b;
  // state, pair index and per-operand shift counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      sa    <= '0;
      sb    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) k <= '0;
      else if (state == WRITE && k != LAST) k <= k + 3'd1;
      sa <= (state == LOAD_B) ? 4'd0 : sa + 4'(shl_a);
      sb <= (state == LOAD_B) ? 4'd0 : sb + 4'(shl_b);
    end
  end
  // next-state sequencing and decoded datapath strobes
  always_comb begin
    state_n = state;
    shl_a   = (state == NORM) && !bus.msb_a && (sa < MAX);
    shl_b   = (state == NORM) && !bus.msb_b && (sb < MAX);
    case (state)
      IDLE:    state_n = bus.start ? LOAD_A : IDLE;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = NORM;
      NORM:    state_n = (shl_a || shl_b) ? NORM : CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = (k == LAST) ? DONE : LOAD_A;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    bus.in_addr     = (state == LOAD_A) ? {k, 1'b0} : (state == LOAD_B) ? {k, 1'b1} : 4'd0;
    bus.ld_a        = (state == LOAD_A);
    bus.ld_b        = (state == LOAD_B);
    bus.shl_a       = shl_a;
    bus.shl_b       = shl_b;
    bus.reg_ld      = (state == CAPTURE);
    bus.shift_total = (state == CAPTURE || state == WRITE) ? 5'(sa) + 5'(sb) : 5'd0;
    bus.out_wen     = (state == WRITE);
    bus.out_addr    = k;
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
  end
endmodule

// File: tb/tb_approx_mult_ctrl.sv
// tb_approx_mult_ctrl: randomized scoreboard check of the sequencer driving a modelled datapath
module tb_approx_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_ram [16];
  logic [15:0] sra = '0, srb = '0;
  logic [7:0]  opa = '0, opb = '0;
  logic [31:0] out_ram [8];
  int          vectors = 0, errors = 0;
  int          na [8], nb [8], nrm [8], st [8], wc [8];
  int          addr_q [$];
  logic [10:0] exp1 [7];

  approx_mult_ctrl_if if8 ();
  approx_mult_ctrl_if if1 ();

  approx_mult_ctrl #(.N_PAIRS(8), .MAX_SHIFT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  approx_mult_ctrl #(.N_PAIRS(1), .MAX_SHIFT(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  assign if8.msb_a = sra[15];
  assign if8.msb_b = srb[15];
  assign if1.msb_a = 1'b1;
  assign if1.msb_b = 1'b1;

  // datapath model: shift registers, operand registers, multiplier and output RAM
  always @(posedge clk) begin
    if (if8.ld_a) sra <= in_ram[if8.in_addr];
    else if (if8.shl_a) sra <= sra << 1;
    if (if8.ld_b) srb <= in_ram[if8.in_addr];
    else if (if8.shl_b) srb <= srb << 1;
    if (if8.reg_ld) begin
      opa <= sra[15:8];
      opb <= srb[15:8];
    end
    if (if8.out_wen) out_ram[if8.out_addr] <= (32'(opa) * 32'(opb)) << (16 - int'(if8.shift_total));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lz(input logic [15:0] x);
    int n = 0;
    while (n < 8 && x[15-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [19:0] outs8();
    return {if8.busy, if8.done, if8.ld_a, if8.ld_b, if8.shl_a, if8.shl_b, if8.reg_ld, if8.out_wen,
            if8.in_addr, if8.out_addr, if8.shift_total};
  endfunction

  function automatic logic [15:0] rnd_op();
    return 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) in_ram[i] = rnd_op();
  endtask

  task automatic run8(output int dcyc);
    int cyc = 0, viol = 0, lbc = 0;
    logic [2:0] p;
    addr_q.delete();
    for (int i = 0; i < 8; i++) begin
      na[i] = 0; nb[i] = 0; nrm[i] = -1; st[i] = -1; wc[i] = 0;
    end
    dcyc = -1;
    @(negedge clk) if8.start = 1'b1;
    while (cyc < 2000 && dcyc < 0) begin
      @(negedge clk);
      cyc++;
      if8.start = 1'($urandom_range(0, 1));
      p = if8.out_addr;
      if ((if8.ld_a || if8.ld_b) && (if8.shl_a || if8.shl_b)) viol++;
      if (!if8.busy) viol++;
      if (if8.ld_a || if8.ld_b) addr_q.push_back(int'(if8.in_addr));
      if (if8.ld_b) lbc = cyc;
      na[p] += int'(if8.shl_a);
      nb[p] += int'(if8.shl_b);
      if (if8.reg_ld) nrm[p] = cyc - lbc - 1;
      if (if8.out_wen) begin
        wc[p]++;
        st[p] = int'(if8.shift_total);
      end
      if (if8.done) begin
        dcyc = cyc;
        if8.start = 1'b0;
      end
    end
    chk("run_timeout", 32'(dcyc < 0), 32'd0);
    chk("strobe_busy_viol", 32'(viol), 32'd0);
    @(negedge clk);
    chk("idle_after_done", {30'd0, if8.busy, if8.done}, 32'd0);
  endtask

  task automatic check8(input int dcyc);
    int total = 1, ea, eb;
    logic [15:0] an, bn;
    chk("addr_count", 32'(addr_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < addr_q.size(); i++) chk($sformatf("in_addr%0d", i), 32'(addr_q[i]), 32'(i));
    for (int p = 0; p < 8; p++) begin
      ea = lz(in_ram[2*p]);
      eb = lz(in_ram[2*p+1]);
      an = in_ram[2*p] << ea;
      bn = in_ram[2*p+1] << eb;
      total += 5 + (ea > eb ? ea : eb);
      chk($sformatf("shl_a_cnt%0d", p), 32'(na[p]), 32'(ea));
      chk($sformatf("shl_b_cnt%0d", p), 32'(nb[p]), 32'(eb));
      chk($sformatf("norm_len%0d", p), 32'(nrm[p]), 32'((ea > eb ? ea : eb) + 1));
      chk($sformatf("shift_total%0d", p), 32'(st[p]), 32'(ea + eb));
      chk($sformatf("wen_cnt%0d", p), 32'(wc[p]), 32'd1);
      chk($sformatf("product%0d", p), out_ram[p], (32'(an[15:8]) * 32'(bn[15:8])) << (16 - ea - eb));
    end
    chk("run_latency", 32'(dcyc), 32'(total));
  endtask

  task automatic pre1();
    logic [10:0] got;
    @(negedge clk) if1.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if1.start = 1'b0;
      got = {if1.ld_a, if1.ld_b, if1.shl_a | if1.shl_b, if1.reg_ld, if1.out_wen, if1.done, if1.busy, if1.in_addr};
      chk($sformatf("pre_cycle%0d", c), 32'(got), 32'(exp1[c-1]));
      if (c == 5) chk("pre_write_addr_st", {24'd0, if1.out_addr, if1.shift_total}, 32'd0);
    end
  endtask

  task automatic reset_mid();
    int cyc = 0;
    bit hit = 1'b0, armed = 1'b0;
    @(negedge clk) if8.start = 1'b1;
    while (cyc < 1000 && !hit) begin
      @(negedge clk);
      cyc++;
      if8.start = 1'b0;
      if (armed) begin
        hit = 1'b1;
        chk("norm3_state", {31'd0, if8.busy}, 32'd1);
        rst = 1'b1;
      end
      if (if8.ld_b && if8.in_addr == 4'd7) armed = 1'b1;
    end
    chk("norm3_reached", 32'(hit), 32'd1);
    @(negedge clk);
    chk("mid_reset_outs", 32'(outs8()), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int dcyc;
    exp1[0] = {7'b1000001, 4'd0};
    exp1[1] = {7'b0100001, 4'd1};
    exp1[2] = {7'b0000001, 4'd0};
    exp1[3] = {7'b0001001, 4'd0};
    exp1[4] = {7'b0000101, 4'd0};
    exp1[5] = {7'b0000011, 4'd0};
    exp1[6] = {7'b0000000, 4'd0};
    if8.start = 1'b1;
    if1.start = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs8", 32'(outs8()), 32'd0);
    chk("reset_outs1", {26'd0, if1.busy, if1.ld_a, if1.ld_b, if1.done, if1.out_wen, if1.reg_ld}, 32'd0);
    rst = 1'b0;
    if8.start = 1'b0;
    if1.start = 1'b0;
    pre1();
    fill_random();
    in_ram[0] = 16'h1000;
    in_ram[1] = 16'h0400;
    in_ram[2] = 16'h0000;
    in_ram[3] = 16'h8000;
    run8(dcyc);
    check8(dcyc);
    chk("unequal_shl_a", 32'(na[0]), 32'd3);
    chk("unequal_shl_b", 32'(nb[0]), 32'd5);
    chk("unequal_norm", 32'(nrm[0]), 32'd6);
    chk("unequal_st", 32'(st[0]), 32'd8);
    chk("zero_shl_a", 32'(na[1]), 32'd8);
    chk("zero_shl_b", 32'(nb[1]), 32'd0);
    chk("zero_st", 32'(st[1]), 32'd8);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run8(dcyc);
      check8(dcyc);
    end
    fill_random();
    reset_mid();
    fill_random();
    run8(dcyc);
    check8(dcyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
